wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and long-latency results onto the single register-file
// write port, queues losing long results, and tracks pending long destinations.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd_num,
   input  logic [31:0] alu_rd_data,
   input  logic        lng_valid,
   output logic        lng_ready,
   input  logic [4:0]  lng_rd_num,
   input  logic [31:0] lng_rd_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd_num,
   input  logic [4:0]  rs_num,
   input  logic [4:0]  rt_num,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic [4:0]  rd_num,
   output logic [31:0] rd_data,
   output logic        rd_we,
   output logic        wb_idle,
   output logic        err_hazard
);

   // Handshake: a long result transfers on a cycle where lng_valid && lng_ready;
   // the ALU source has no handshake and always wins when present.
   logic [4:0]    fifo_num  [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   busy, busy_next, busy_set, busy_clr;

   logic        fifo_empty, fifo_full, lng_fire;
   logic        win, win_long, push, pop, hazard;
   logic [4:0]  win_num;
   logic [31:0] win_data;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (AW+1)'(DEPTH));
   assign lng_ready  = !fifo_full;
   assign lng_fire   = lng_valid && lng_ready;

   // Queued long results are always drained before a new one may go direct,
   // so long results commit strictly in arrival order.
   always_comb begin
      win      = 1'b0;
      win_long = 1'b0;
      win_num  = alu_rd_num;
      win_data = alu_rd_data;
      push     = 1'b0;
      pop      = 1'b0;
      if (alu_valid) begin
         win  = 1'b1;
         push = lng_fire;
      end else if (!fifo_empty) begin
         win      = 1'b1;
         win_long = 1'b1;
         pop      = 1'b1;
         win_num  = fifo_num[rd_ptr];
         win_data = fifo_data[rd_ptr];
         push     = lng_fire;
      end else if (lng_fire) begin
         win      = 1'b1;
         win_long = 1'b1;
         win_num  = lng_rd_num;
         win_data = lng_rd_data;
      end
   end

   always_comb begin
      busy_clr  = win_long  ? (32'd1 << win_num)    : 32'd0;
      busy_set  = iss_valid ? (32'd1 << iss_rd_num) : 32'd0;
      busy_next = ((busy & ~busy_clr) | busy_set) & ~32'd1;
   end

   assign hazard = (iss_valid && busy[iss_rd_num])
                || (alu_valid && busy[alu_rd_num])
                || (lng_valid && (lng_rd_num != 5'd0) && !busy[lng_rd_num]);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_num[wr_ptr]  <= lng_rd_num;
         fifo_data[wr_ptr] <= lng_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         busy       <= '0;
         rd_we      <= 1'b0;
         rd_num     <= '0;
         rd_data    <= '0;
         err_hazard <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
         busy <= busy_next;
         // r0 results are consumed but never reach the register file
         rd_we <= win && (win_num != 5'd0);
         if (win) begin
            rd_num  <= win_num;
            rd_data <= win_data;
         end
         if (hazard) err_hazard <= 1'b1;
      end
   end

   assign rs_busy = busy[rs_num];
   assign rt_busy = busy[rt_num];
   assign wb_idle = fifo_empty && (busy == 32'd0) && !rd_we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, collision/ordering sequence,
// then randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd_num;
   logic [31:0] alu_rd_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_rd_num;
   logic [31:0] lng_rd_data;
   logic        iss_valid;
   logic [4:0]  iss_rd_num;
   logic [4:0]  rs_num;
   logic [4:0]  rt_num;
   logic        rs_busy;
   logic        rt_busy;
   logic [4:0]  rd_num;
   logic [31:0] rd_data;
   logic        rd_we;
   logic        wb_idle;
   logic        err_hazard;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd_num(alu_rd_num), .alu_rd_data(alu_rd_data),
      .lng_valid(lng_valid), .lng_ready(lng_ready),
      .lng_rd_num(lng_rd_num), .lng_rd_data(lng_rd_data),
      .iss_valid(iss_valid), .iss_rd_num(iss_rd_num),
      .rs_num(rs_num), .rt_num(rt_num), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .rd_num(rd_num), .rd_data(rd_data), .rd_we(rd_we),
      .wb_idle(wb_idle), .err_hazard(err_hazard)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending long results as a queue, busy set as a bit vector.
   logic [36:0] m_q[$];
   logic [31:0] m_busy;
   logic        m_err, m_we, m_known;
   logic [4:0]  m_num;
   logic [31:0] m_data;

   task automatic model_reset();
      m_q.delete();
      m_busy  = '0;
      m_err   = 1'b0;
      m_we    = 1'b0;
      m_num   = '0;
      m_data  = '0;
      m_known = 1'b1;
   endtask

   task automatic model_check();
      chk("lng_ready", 32'(lng_ready), 32'(m_q.size() < DEPTH));
      chk("rs_busy", 32'(rs_busy), 32'((rs_num != 0) && m_busy[rs_num]));
      chk("rt_busy", 32'(rt_busy), 32'((rt_num != 0) && m_busy[rt_num]));
      chk("rd_we", 32'(rd_we), 32'(m_we));
      if (m_known) begin
         chk("rd_num", 32'(rd_num), 32'(m_num));
         chk("rd_data", rd_data, m_data);
      end
      chk("err_hazard", 32'(err_hazard), 32'(m_err));
      chk("wb_idle", 32'(wb_idle), 32'((m_q.size() == 0) && (m_busy == 0) && !m_we));
   endtask

   task automatic model_update();
      logic [36:0] w;
      logic        have, lng_w, fire, direct;
      logic [31:0] nb;
      if (rst) begin
         model_reset();
         return;
      end
      w = '0; have = 1'b0; lng_w = 1'b0; direct = 1'b0;
      fire = lng_valid && (m_q.size() < DEPTH);
      if ((iss_valid && m_busy[iss_rd_num]) || (alu_valid && m_busy[alu_rd_num]) ||
          (lng_valid && lng_rd_num != 0 && !m_busy[lng_rd_num]))
         m_err = 1'b1;
      if (alu_valid) begin
         have = 1'b1; w = {alu_rd_num, alu_rd_data};
      end else if (m_q.size() > 0) begin
         have = 1'b1; lng_w = 1'b1; w = m_q.pop_front();
      end else if (fire) begin
         have = 1'b1; lng_w = 1'b1; direct = 1'b1; w = {lng_rd_num, lng_rd_data};
      end
      if (fire && !direct) m_q.push_back({lng_rd_num, lng_rd_data});
      nb = m_busy;
      if (lng_w) nb[w[36:32]] = 1'b0;
      if (iss_valid) nb[iss_rd_num] = 1'b1;
      nb[0] = 1'b0;
      m_busy = nb;
      m_we = have && (w[36:32] != 0);
      if (have) begin
         if (w[36:32] != 0) begin
            m_num = w[36:32]; m_data = w[31:0]; m_known = 1'b1;
         end else begin
            m_known = 1'b0;
         end
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_rd_num = 0; alu_rd_data = 0;
      lng_valid = 0; lng_rd_num = 0; lng_rd_data = 0;
      iss_valid = 0; iss_rd_num = 0; rs_num = 0; rt_num = 0;
   endtask

   task automatic settle_and_check();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rst; logic iss_v; logic [4:0] iss_rd;
      logic alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
      logic lng_v; logic [4:0] lng_rd; logic [31:0] lng_d;
      logic [4:0] rs;
      logic e_we; logic e_chk; logic [4:0] e_num; logic [31:0] e_data;
      logic e_ready; logic e_rsb; logic e_err; logic e_idle;
   } vec_t;

   vec_t vecs[20];
   logic [36:0] exp_q[$];
   logic [36:0] obs_q[$];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // expectations are outputs seen before the row's own clock edge
      vecs[0]  = '{0, 0,0, 0,0,0, 0,0,0, 5,  0,1,0,0,             1,0,0,1};
      vecs[1]  = '{0, 1,5, 0,0,0, 0,0,0, 5,  0,1,0,0,             1,0,0,1};
      vecs[2]  = '{0, 0,0, 0,0,0, 1,5,32'hDEADBEEF, 5, 0,1,0,0,   1,1,0,0};
      vecs[3]  = '{0, 0,0, 0,0,0, 0,0,0, 5,  1,1,5,32'hDEADBEEF,  1,0,0,0};
      vecs[4]  = '{0, 0,0, 0,0,0, 1,0,32'hFFFFFFFF, 5, 0,1,5,32'hDEADBEEF, 1,0,0,1};
      vecs[5]  = '{0, 0,0, 0,0,0, 0,0,0, 0,  0,0,0,0,             1,0,0,1};
      vecs[6]  = '{0, 1,7, 0,0,0, 0,0,0, 7,  0,0,0,0,             1,0,0,1};
      vecs[7]  = '{0, 1,7, 0,0,0, 1,7,32'h77, 7, 0,0,0,0,         1,1,0,0};
      vecs[8]  = '{0, 0,0, 0,0,0, 0,0,0, 7,  1,1,7,32'h77,        1,1,1,0};
      vecs[9]  = '{1, 0,0, 0,0,0, 0,0,0, 7,  0,1,7,32'h77,        1,1,1,0};
      vecs[10] = '{0, 0,0, 0,0,0, 0,0,0, 7,  0,1,0,0,             1,0,0,1};
      vecs[11] = '{0, 1,9, 0,0,0, 0,0,0, 9,  0,1,0,0,             1,0,0,1};
      vecs[12] = '{0, 0,0, 1,9,32'h99, 0,0,0, 9, 0,1,0,0,         1,1,0,0};
      vecs[13] = '{0, 0,0, 0,0,0, 0,0,0, 9,  1,1,9,32'h99,        1,1,1,0};
      vecs[14] = '{0, 0,0, 0,0,0, 0,0,0, 9,  0,1,9,32'h99,        1,1,1,0};
      vecs[15] = '{1, 0,0, 0,0,0, 0,0,0, 9,  0,1,9,32'h99,        1,1,1,0};
      vecs[16] = '{0, 0,0, 0,0,0, 1,4,32'h44, 4, 0,1,0,0,         1,0,0,1};
      vecs[17] = '{0, 0,0, 0,0,0, 0,0,0, 4,  1,1,4,32'h44,        1,0,1,0};
      vecs[18] = '{1, 0,0, 0,0,0, 0,0,0, 4,  0,1,4,32'h44,        1,0,1,1};
      vecs[19] = '{0, 0,0, 0,0,0, 0,0,0, 0,  0,1,0,0,             1,0,0,1};

      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      for (int i = 0; i < 20; i++) begin
         rst = vecs[i].rst;
         iss_valid = vecs[i].iss_v; iss_rd_num = vecs[i].iss_rd;
         alu_valid = vecs[i].alu_v; alu_rd_num = vecs[i].alu_rd; alu_rd_data = vecs[i].alu_d;
         lng_valid = vecs[i].lng_v; lng_rd_num = vecs[i].lng_rd; lng_rd_data = vecs[i].lng_d;
         rs_num = vecs[i].rs; rt_num = 0;
         settle_and_check();
         chk($sformatf("vec%0d_rd_we", i), 32'(rd_we), 32'(vecs[i].e_we));
         if (vecs[i].e_chk) begin
            chk($sformatf("vec%0d_rd_num", i), 32'(rd_num), 32'(vecs[i].e_num));
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
         end
         chk($sformatf("vec%0d_lng_ready", i), 32'(lng_ready), 32'(vecs[i].e_ready));
         chk($sformatf("vec%0d_rs_busy", i), 32'(rs_busy), 32'(vecs[i].e_rsb));
         chk($sformatf("vec%0d_rt_busy_r0", i), 32'(rt_busy), 32'd0);
         chk($sformatf("vec%0d_err", i), 32'(err_hazard), 32'(vecs[i].e_err));
         chk($sformatf("vec%0d_idle", i), 32'(wb_idle), 32'(vecs[i].e_idle));
         advance();
      end
      rst = 1'b0;
      idle_inputs();

      // ALU holds the port for 6 cycles while r8..r12 queue up behind it
      for (int r = 8; r <= 12; r++) begin
         iss_valid = 1; iss_rd_num = 5'(r);
         settle_and_check();
         advance();
      end
      idle_inputs();
      exp_q.delete();
      obs_q.delete();
      for (int k = 0; k < 6; k++) exp_q.push_back({5'd3, 32'h11});
      for (int r = 8; r <= 12; r++) exp_q.push_back({5'(r), 32'h800 + 32'(r)});
      begin
         int idx = 0;
         for (int k = 0; k < 30 && obs_q.size() < 11; k++) begin
            alu_valid = (k < 6); alu_rd_num = 3; alu_rd_data = 32'h11;
            lng_valid = (idx < 5);
            lng_rd_num = 5'(8 + idx); lng_rd_data = 32'h800 + 32'(8 + idx);
            settle_and_check();
            if (rd_we) obs_q.push_back({rd_num, rd_data});
            if (k == 4 || k == 5) chk($sformatf("t3_ready_low_c%0d", k), 32'(lng_ready), 32'd0);
            if (lng_valid && lng_ready) idx++;
            advance();
         end
      end
      idle_inputs();
      chk("t3_write_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         chk($sformatf("t3_write%0d", k), 32'(obs_q[k]), 32'(exp_q[k]));
      chk("t3_write_hi", 32'(obs_q.size() > 10 ? obs_q[10][36:32] : 5'd0), 32'd12);
      settle_and_check();
      advance();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         iss_valid = ($urandom_range(0, 3) == 0); iss_rd_num = 5'($urandom_range(0, 7));
         alu_valid = ($urandom_range(0, 9) < 3);  alu_rd_num = 5'($urandom_range(0, 7));
         alu_rd_data = $urandom();
         lng_valid = ($urandom_range(0, 1) == 0); lng_rd_num = 5'($urandom_range(0, 7));
         lng_rd_data = $urandom();
         rs_num = 5'($urandom_range(0, 9)); rt_num = 5'($urandom_range(0, 31));
         settle_and_check();
         advance();
      end

      // reset held two cycles in the middle of traffic
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         alu_valid = 1; alu_rd_num = 5'($urandom_range(1, 7)); alu_rd_data = $urandom();
         lng_valid = 1; lng_rd_num = 5'($urandom_range(1, 7)); lng_rd_data = $urandom();
         iss_valid = 1; iss_rd_num = 5'($urandom_range(1, 7));
         settle_and_check();
         advance();
      end
      rst = 1'b0;
      idle_inputs();
      for (int r = 0; r < 32; r++) begin
         rs_num = 5'(r); rt_num = 5'(31 - r);
         settle_and_check();
         chk($sformatf("t1_rs_busy_r%0d", r), 32'(rs_busy), 32'd0);
         if (r == 0) begin
            chk("t1_rd_we", 32'(rd_we), 32'd0);
            chk("t1_lng_ready", 32'(lng_ready), 32'd1);
            chk("t1_wb_idle", 32'(wb_idle), 32'd1);
            chk("t1_err", 32'(err_hazard), 32'd0);
         end
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
